// File: rtl/wubsuit_gpi_pkg.sv
// Shared constants for the wubsuit GPI APB block: register offsets and APB data width.
package wubsuit_gpi_pkg;

  localparam int unsigned APB_DW = 32;

  localparam int unsigned OFS_DATA     = 32'h00;
  localparam int unsigned OFS_RAW      = 32'h04;
  localparam int unsigned OFS_STATUS   = 32'h08;
  localparam int unsigned OFS_IRQEN    = 32'h0C;
  localparam int unsigned OFS_EDGESEL  = 32'h10;
  localparam int unsigned OFS_BOTH     = 32'h14;
  localparam int unsigned OFS_DEBOUNCE = 32'h18;
  localparam int unsigned OFS_TS       = 32'h1C;

endpackage

// File: rtl/wubsuit_gpi_debounce.sv
// One GPI channel: synchroniser chain, debounce counter and debounced level,
// with single-cycle rise/fall pulses aligned to the edge the level updates.
module wubsuit_gpi_debounce #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  gpi_i,
  input  logic [DEBOUNCE_W-1:0] thresh_i,
  output logic                  raw_o,
  output logic                  data_o,
  output logic                  rise_o,
  output logic                  fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DEBOUNCE_W-1:0]  cnt_q, cnt_d, limit;
  logic                   data_q, data_d, raw, upd;

  assign raw = sync_q[SYNC_STAGES-1];

  // A zero threshold collapses to the same limit as one: update on the first mismatch cycle.
  always_comb begin
    limit  = (thresh_i == '0) ? '0 : thresh_i - DEBOUNCE_W'(1);
    upd    = (raw != data_q) && (cnt_q >= limit);
    data_d = data_q;
    cnt_d  = '0;
    if (upd) begin
      data_d = raw;
    end else if (raw != data_q) begin
      cnt_d = cnt_q + DEBOUNCE_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
      cnt_q  <= '0;
      data_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpi_i};
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end

  assign raw_o  = raw;
  assign data_o = data_q;
  assign rise_o = upd & raw;
  assign fall_o = upd & ~raw;

endmodule

// File: rtl/wubsuit_gpi_apb.sv
// Fabric GPI block on the MSS APB3 bus: per-channel debounce, edge capture, W1C status, level IRQ.
// Optional edge timestamp register enabled by defining WUBSUIT_GPI_TIMESTAMP_EN.
module wubsuit_gpi_apb
  import wubsuit_gpi_pkg::*;
#(
  parameter int unsigned              NUM_CH       = 11,
  parameter int unsigned              SYNC_STAGES  = 2,
  parameter int unsigned              DEBOUNCE_W   = 16,
  parameter logic [DEBOUNCE_W-1:0]    DEBOUNCE_RST = 16'd1000,
  parameter int unsigned              ADDR_W       = 8
) (
  input  logic              SYSCLK,
  input  logic              NSYSRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [NUM_CH-1:0] GPI_IN,
  output logic              IRQ
);

  logic [NUM_CH-1:0]     raw_w, data_w, rise_w, fall_w, set_v, w1c;
  logic [NUM_CH-1:0]     status_q, status_d, irqen_q, edgesel_q, both_q;
  logic [DEBOUNCE_W-1:0] deb_q;
  logic                  irq_q;
  logic [ADDR_W-1:0]     ofs;
  logic [APB_DW-1:0]     rdata;
  logic                  acc, mapped, ro, err, wr_ok;
  logic                  unused_bits;

`ifdef WUBSUIT_GPI_TIMESTAMP_EN
  logic [31:0] tscnt_q, ts_q;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    wubsuit_gpi_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_W  (DEBOUNCE_W)
    ) u_deb (
      .clk_i    (SYSCLK),
      .rst_ni   (NSYSRESET),
      .gpi_i    (GPI_IN[g]),
      .thresh_i (deb_q),
      .raw_o    (raw_w[g]),
      .data_o   (data_w[g]),
      .rise_o   (rise_w[g]),
      .fall_o   (fall_w[g])
    );
  end

  assign unused_bits = ^{PWDATA, PADDR[1:0]};

  always_comb begin
    acc    = PSEL & PENABLE;
    ofs    = {PADDR[ADDR_W-1:2], 2'b00};
    rdata  = '0;
    mapped = 1'b1;
    ro     = 1'b0;
    case (ofs)
      ADDR_W'(OFS_DATA):     begin rdata = APB_DW'(data_w); ro = 1'b1; end
      ADDR_W'(OFS_RAW):      begin rdata = APB_DW'(raw_w);  ro = 1'b1; end
      ADDR_W'(OFS_STATUS):   rdata = APB_DW'(status_q);
      ADDR_W'(OFS_IRQEN):    rdata = APB_DW'(irqen_q);
      ADDR_W'(OFS_EDGESEL):  rdata = APB_DW'(edgesel_q);
      ADDR_W'(OFS_BOTH):     rdata = APB_DW'(both_q);
      ADDR_W'(OFS_DEBOUNCE): rdata = APB_DW'(deb_q);
`ifdef WUBSUIT_GPI_TIMESTAMP_EN
      ADDR_W'(OFS_TS):       rdata = ts_q;
`else
      ADDR_W'(OFS_TS):       mapped = 1'b0;
`endif
      default:               mapped = 1'b0;
    endcase
    err    = acc & (~mapped | (PWRITE & ro));
    wr_ok  = acc & PWRITE & ~err;
    PRDATA = (acc & mapped) ? rdata : '0;
  end

  // Set takes priority over a W1C of the same bit on the same edge.
  always_comb begin
    set_v    = (both_q & (rise_w | fall_w)) |
               (~both_q & ((edgesel_q & fall_w) | (~edgesel_q & rise_w)));
    w1c      = (wr_ok && ofs == ADDR_W'(OFS_STATUS)) ? PWDATA[NUM_CH-1:0] : '0;
    status_d = (status_q & ~w1c) | set_v;
  end

  always_ff @(posedge SYSCLK) begin
    if (!NSYSRESET) begin
      status_q  <= '0;
      irqen_q   <= '0;
      edgesel_q <= '0;
      both_q    <= '0;
      deb_q     <= DEBOUNCE_RST;
      irq_q     <= 1'b0;
    end else begin
      status_q <= status_d;
      irq_q    <= |(status_q & irqen_q);
      if (wr_ok) begin
        case (ofs)
          ADDR_W'(OFS_IRQEN):    irqen_q   <= PWDATA[NUM_CH-1:0];
          ADDR_W'(OFS_EDGESEL):  edgesel_q <= PWDATA[NUM_CH-1:0];
          ADDR_W'(OFS_BOTH):     both_q    <= PWDATA[NUM_CH-1:0];
          ADDR_W'(OFS_DEBOUNCE): deb_q     <= PWDATA[DEBOUNCE_W-1:0];
          default: ;
        endcase
      end
    end
  end

`ifdef WUBSUIT_GPI_TIMESTAMP_EN
  always_ff @(posedge SYSCLK) begin
    if (!NSYSRESET) begin
      tscnt_q <= '0;
      ts_q    <= '0;
    end else begin
      tscnt_q <= tscnt_q + 32'd1;
      if (|set_v) ts_q <= tscnt_q;
    end
  end
`endif

  assign PSLVERR = err;
  assign PREADY  = 1'b1;
  assign IRQ     = irq_q;

endmodule
